flash_read_arbiter: RTL and testbench



---
 rtl/flash_arb_pkg.sv | 11 +
 rtl/flash_read_arbiter_rr_pick2.sv | 16 +
 rtl/flash_read_arbiter.sv | 128 ++++++++++++
 tb/tb_flash_read_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared encodings for the two-requester flash read arbiter.
package flash_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam logic REQ_LUT = 1'b0;
  localparam logic REQ_CAL = 1'b1;
endpackage

// File: rtl/flash_read_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
import flash_arb_pkg::*;

module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic any,
  output logic winner
);
  always_comb begin
    any    = valid0 | valid1;
    winner = REQ_LUT;
    if (valid1 && (!valid0 || last_grant == REQ_LUT)) winner = REQ_CAL;
  end
endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing the flash read port between the LUT path and
// the calibration loader, with a bounded per-transaction timeout.
import flash_arb_pkg::*;

module flash_read_arbiter #(
  parameter int                 ADDR_W         = 24,
  parameter int                 DATA_W         = 8,
  parameter int                 TIMEOUT_CYCLES = 1023,
  parameter logic [DATA_W-1:0]  ERR_DATA       = 8'hFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_address,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_address,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] fd_address,
  output logic              fd_valid,
  input  logic              fd_ready,
  input  logic [DATA_W-1:0] fd,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err
);
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                last_grant, last_grant_d;
  logic [ADDR_W-1:0]   fd_address_d;
  logic                fd_valid_d, grant_id_d, busy_d, timeout_err_d;
  logic                req0_ready_d, req1_ready_d;
  logic [DATA_W-1:0]   req0_rdata_d, req1_rdata_d;
  logic                pick_any, pick_win;

  rr_pick2 u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_win)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= REQ_CAL;
      fd_address  <= '0;
      fd_valid    <= 1'b0;
      grant_id    <= REQ_LUT;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      last_grant  <= last_grant_d;
      fd_address  <= fd_address_d;
      fd_valid    <= fd_valid_d;
      grant_id    <= grant_id_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
      req0_ready  <= req0_ready_d;
      req1_ready  <= req1_ready_d;
      req0_rdata  <= req0_rdata_d;
      req1_rdata  <= req1_rdata_d;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    last_grant_d  = last_grant;
    fd_address_d  = fd_address;
    fd_valid_d    = fd_valid;
    grant_id_d    = grant_id;
    busy_d        = busy;
    timeout_err_d = 1'b0;
    req0_ready_d  = 1'b0;
    req1_ready_d  = 1'b0;
    req0_rdata_d  = req0_rdata;
    req1_rdata_d  = req1_rdata;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_d      = BUSY;
          fd_address_d = (pick_win == REQ_CAL) ? req1_address : req0_address;
          fd_valid_d   = 1'b1;
          grant_id_d   = pick_win;
          busy_d       = 1'b1;
          cnt_d        = '0;
        end
      end
      BUSY: begin
        // A real completion beats a timeout landing on the same cycle.
        if (fd_ready || cnt == CNT_LAST) begin
          if (grant_id == REQ_CAL) begin
            req1_rdata_d = fd_ready ? fd : ERR_DATA;
            req1_ready_d = 1'b1;
          end else begin
            req0_rdata_d = fd_ready ? fd : ERR_DATA;
            req0_ready_d = 1'b1;
          end
          timeout_err_d = !fd_ready;
          fd_valid_d    = 1'b0;
          last_grant_d  = grant_id;
          state_d       = GAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed scoreboard bench for flash_read_arbiter with an 8-cycle timeout.
module tb_flash_read_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0] req0_address = '0, req1_address = '0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_rdata, req1_rdata;
  logic [23:0] fd_address;
  logic        fd_valid;
  logic        fd_ready = 1'b0;
  logic [7:0]  fd = '0;
  logic        grant_id, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  flash_read_arbiter #(.ADDR_W(24), .DATA_W(8), .TIMEOUT_CYCLES(8), .ERR_DATA(8'hFF)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_address(req0_address), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_address(req1_address), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .fd_address(fd_address), .fd_valid(fd_valid), .fd_ready(fd_ready), .fd(fd),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Completion monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && (req0_ready || req1_ready)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ready_both", {req0_ready, req1_ready}, e.id ? 2'b01 : 2'b10);
        chk("rdata", e.id ? req1_rdata : req0_rdata, e.data);
        chk("timeout_err", timeout_err, e.err);
      end
    end else if (rstn) begin
      chk("stray_timeout_err", timeout_err, 0);
    end
  end

  task automatic txn(input logic id, input logic [23:0] addr, input int wc,
                     input logic [7:0] data, input bit to, input bit drop);
    int n;
    n = 0;
    while (!fd_valid && n < 40) begin @(negedge clk); n++; end
    chk("grant_seen", fd_valid, 1);
    chk("grant_id", grant_id, id);
    chk("fd_address", fd_address, addr);
    chk("busy", busy, 1);
    if (drop) begin
      req0_address = ~addr;
      req0_valid   = 1'b0;
    end
    if (to) begin
      exp_q.push_back('{id, 8'hFF, 1'b1});
      n = 0;
      while (fd_valid && n < 40) begin n++; @(negedge clk); end
      chk("fd_valid_len", n, 8);
    end else begin
      for (int i = 0; i < wc; i++) begin
        @(negedge clk);
        chk("addr_hold", {fd_valid, fd_address}, {1'b1, addr});
      end
      exp_q.push_back('{id, data, 1'b0});
      fd_ready = 1'b1;
      fd       = data;
      @(negedge clk);
      fd_ready = 1'b0;
    end
    chk("gap_fd_valid_low", fd_valid, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_outputs", {fd_valid, fd_address, req0_ready, req1_ready, req0_rdata, req1_rdata,
                        grant_id, busy, timeout_err}, '0);
    do_reset();

    // Single LUT read
    req0_address = 24'h012345; req0_valid = 1'b1;
    txn(1'b0, 24'h012345, 3, 8'h5A, 0, 0);
    req0_valid = 1'b0;

    // fd_ready while idle is ignored
    repeat (2) @(negedge clk);
    fd_ready = 1'b1; fd = 8'hAA;
    @(negedge clk);
    fd_ready = 1'b0;
    @(negedge clk);
    chk("idle_fd_ready_ignored", {busy, fd_valid}, 2'b00);

    // Both requesters held: strict alternation from reset
    do_reset();
    req0_address = 24'h000100; req1_address = 24'hABC000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    txn(1'b0, 24'h000100, 0, 8'h11, 0, 0);
    txn(1'b1, 24'hABC000, 1, 8'h22, 0, 0);
    txn(1'b0, 24'h000100, 2, 8'h33, 0, 0);
    txn(1'b1, 24'hABC000, 0, 8'h44, 0, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Timeout on requester 1, then a normal grant
    repeat (2) @(negedge clk);
    req1_address = 24'h777777; req1_valid = 1'b1;
    txn(1'b1, 24'h777777, 0, 8'h00, 1, 0);
    req1_valid = 1'b0;
    req0_address = 24'h0000C3; req0_valid = 1'b1;
    txn(1'b0, 24'h0000C3, 1, 8'h96, 0, 0);
    req0_valid = 1'b0;

    // fd_ready on the timeout cycle: real data, no error
    @(negedge clk);
    req0_address = 24'h010203; req0_valid = 1'b1;
    txn(1'b0, 24'h010203, 7, 8'h3C, 0, 0);
    req0_valid = 1'b0;

    // Address change and valid drop mid-transaction
    @(negedge clk);
    req0_address = 24'h5A5A5A; req0_valid = 1'b1;
    txn(1'b0, 24'h5A5A5A, 3, 8'hC7, 0, 1);

    // Reset mid-BUSY
    repeat (2) @(negedge clk);
    req0_address = 24'h123456; req0_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("pre_reset_busy", {fd_valid, busy}, 2'b11);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("async_reset", {fd_valid, fd_address, busy, grant_id, req0_ready, timeout_err}, '0);
    req1_address = 24'h654321; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    txn(1'b0, 24'h123456, 1, 8'hE1, 0, 0);
    req0_valid = 1'b0;
    txn(1'b1, 24'h654321, 1, 8'hE2, 0, 0);
    req1_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
